ex_mem_skid_stage: RTL and testbench

EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

---
 rtl/ex_mem_skid_pkg.sv | 35 +++
 rtl/ex_mem_skid_stage_payload_reg.sv | 26 ++
 rtl/ex_mem_skid_stage.sv | 151 +++++++++++++++
 tb/tb_ex_mem_skid_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ex_mem_skid_pkg.sv
// Shared definitions for the EX/MEM skid-buffered pipeline stage.
// Holds the FSM state encoding, control-bit positions and default widths.
// Imported by the stage top and its payload register.
package ex_mem_skid_pkg;

    // Default datapath widths
    localparam int DEF_XLEN = 32;
    localparam int DEF_VLEN = 128;
    localparam int DEF_RAW  = 5;

    // Control vector width and bit positions: {RegWrite, MemToReg, MemRead, MemWrite}
    localparam int CTRL_W        = 4;
    localparam int CTRL_REGWRITE = 3;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 0;

    // FSM state encoding; the value doubles as the occupancy count
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Number of entries held in a given state
    function automatic logic [1:0] occ_of(input logic [1:0] state);
        logic [1:0] occ;
        occ = 2'd0;
        case (state)
            ST_ONE:  occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/ex_mem_skid_stage_payload_reg.sv
// Enable-loaded payload register, cleared to zero by synchronous reset.
// Latency: 1 cycle from en_i to q_o. No backpressure; caller decides when to load.
// Ports: clk_i, rst_i (sync, active-high), en_i load enable, d_i data in, q_o data out.
module ex_mem_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer (main + skid), strict FIFO.
// Latency: 1 cycle from accept into an empty stage to valid_o.
// Backpressure: ready_o is registered and drops only when both entries are held.
// Ports: clk_i/rst_i/flush_i; upstream valid_i/ready_o + payload *_i;
//        downstream valid_o/ready_i + payload *_o; occ_o = entries held.
module ex_mem_skid_stage
    import ex_mem_skid_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int VLEN = DEF_VLEN,
    parameter int RAW  = DEF_RAW
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,

    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] alu_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic            zero_i,
    input  logic [VLEN-1:0] valu_i,
    input  logic [RAW-1:0]  rd_addr_i,
    input  logic [3:0]      ctrl_i,

    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] alu_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            zero_o,
    output logic [VLEN-1:0] valu_o,
    output logic [RAW-1:0]  rd_addr_o,
    output logic [3:0]      ctrl_o,
    output logic [1:0]      occ_o
);

    // Whole entry travels as one flat vector; ctrl sits in the low bits
    localparam int PW = 3 * XLEN + 1 + VLEN + RAW + CTRL_W;

    logic [1:0]    r_state;
    logic          r_valid;
    logic          r_ready;
    logic [1:0]    r_occ;

    logic          w_accept;
    logic          w_release;
    logic [1:0]    w_nxt_state;
    logic          w_main_en;
    logic          w_main_from_skid;
    logic          w_skid_en;
    logic [PW-1:0] w_in_payload;
    logic [PW-1:0] w_main_d;
    logic [PW-1:0] w_main_q;
    logic [PW-1:0] w_skid_q;
    logic [3:0]    w_main_ctrl;

    assign w_in_payload = {pc_i, alu_i, rd_data_i, zero_i, valu_i, rd_addr_i, ctrl_i};

    // Next-state and load-enable decode. A flush overrides everything below it,
    // so no register is loaded in a flush cycle and the same-cycle accept is lost.
    always_comb begin
        w_accept         = valid_i && r_ready;
        w_release        = r_valid && ready_i;
        w_nxt_state      = r_state;
        w_main_en        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_en        = 1'b0;
        if (flush_i) begin
            w_nxt_state = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_en   = 1'b1;
                        w_nxt_state = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_release) begin
                        w_main_en = 1'b1;
                    end else if (w_accept) begin
                        // Downstream stalled: park the new entry behind main
                        w_skid_en   = 1'b1;
                        w_nxt_state = ST_FULL;
                    end else if (w_release) begin
                        w_nxt_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_release) begin
                        w_main_en        = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_nxt_state      = ST_ONE;
                    end
                end
                default: begin
                    w_nxt_state = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_payload;

    // Handshake outputs are registered from the next state so they carry no
    // combinational path from ready_i/valid_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_occ   <= 2'd0;
        end else begin
            r_state <= w_nxt_state;
            r_valid <= (w_nxt_state != ST_EMPTY);
            r_ready <= (w_nxt_state != ST_FULL);
            r_occ   <= occ_of(w_nxt_state);
        end
    end

    ex_mem_payload_reg #(
        .W (PW)
    ) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_main_en),
        .d_i   (w_main_d),
        .q_o   (w_main_q)
    );

    ex_mem_payload_reg #(
        .W (PW)
    ) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (w_skid_en),
        .d_i   (w_in_payload),
        .q_o   (w_skid_q)
    );

    assign {pc_o, alu_o, rd_data_o, zero_o, valu_o, rd_addr_o, w_main_ctrl} = w_main_q;

    // A bubble must not carry write/read enables; the rest of the payload just holds
    assign ctrl_o  = r_valid ? w_main_ctrl : 4'b0000;
    assign valid_o = r_valid;
    assign ready_o = r_ready;
    assign occ_o   = r_occ;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
module tb_ex_mem_skid_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default-width DUT ----------------
    logic         rst, flush, vld_in, rdy_in;
    logic         rdy_out, vld_out, zero_in, zero_out;
    logic [31:0]  pc_in, alu_in, rdd_in, pc_out, alu_out, rdd_out;
    logic [127:0] valu_in, valu_out;
    logic [4:0]   rda_in, rda_out;
    logic [3:0]   ctrl_in, ctrl_out;
    logic [1:0]   occ_out;

    ex_mem_skid_stage dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .valid_i(vld_in), .ready_o(rdy_out),
        .pc_i(pc_in), .alu_i(alu_in), .rd_data_i(rdd_in), .zero_i(zero_in),
        .valu_i(valu_in), .rd_addr_i(rda_in), .ctrl_i(ctrl_in),
        .valid_o(vld_out), .ready_i(rdy_in),
        .pc_o(pc_out), .alu_o(alu_out), .rd_data_o(rdd_out), .zero_o(zero_out),
        .valu_o(valu_out), .rd_addr_o(rda_out), .ctrl_o(ctrl_out), .occ_o(occ_out)
    );

    // ---------------- VLEN=256 DUT ----------------
    logic         w_rst, w_flush, w_vld_in, w_rdy_in, w_rdy_out, w_vld_out, w_zero_out;
    logic [31:0]  w_pc_out, w_alu_out, w_rdd_out;
    logic [255:0] w_valu_in, w_valu_out;
    logic [4:0]   w_rda_out;
    logic [3:0]   w_ctrl_in, w_ctrl_out;
    logic [1:0]   w_occ_out;

    ex_mem_skid_stage #(.VLEN(256)) dut_wide (
        .clk_i(clk), .rst_i(w_rst), .flush_i(w_flush),
        .valid_i(w_vld_in), .ready_o(w_rdy_out),
        .pc_i(32'h0000_0700), .alu_i(32'hDEAD_BEEF), .rd_data_i(32'h1234_5678), .zero_i(1'b1),
        .valu_i(w_valu_in), .rd_addr_i(5'd17), .ctrl_i(w_ctrl_in),
        .valid_o(w_vld_out), .ready_i(w_rdy_in),
        .pc_o(w_pc_out), .alu_o(w_alu_out), .rd_data_o(w_rdd_out), .zero_o(w_zero_out),
        .valu_o(w_valu_out), .rd_addr_o(w_rda_out), .ctrl_o(w_ctrl_out), .occ_o(w_occ_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Secondary payload fields are tagged from pc so one expected pc predicts them all
    function automatic logic [31:0]  f_alu(input logic [31:0] pc);  return pc << 4; endfunction
    function automatic logic [31:0]  f_rdd(input logic [31:0] pc);  return pc << 8; endfunction
    function automatic logic [4:0]   f_rda(input logic [31:0] pc);  return pc[6:2]; endfunction
    function automatic logic         f_zero(input logic [31:0] pc); return pc[2];   endfunction
    function automatic logic [127:0] f_valu(input logic [31:0] pc); return {4{pc}}; endfunction

    typedef struct {
        logic        rst, flush, vld, rdy;
        logic [31:0] pc;
        logic [3:0]  ctrl;
        logic        ev, er;
        logic [1:0]  eo;
        logic [31:0] epc;
        logic [3:0]  ectrl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic v, input logic rd,
                       input logic [31:0] pc, input logic [3:0] c,
                       input logic ev, input logic er, input logic [1:0] eo,
                       input logic [31:0] epc, input logic [3:0] ec);
        vec_t t;
        t.rst = r; t.flush = f; t.vld = v; t.rdy = rd; t.pc = pc; t.ctrl = c;
        t.ev = ev; t.er = er; t.eo = eo; t.epc = epc; t.ectrl = ec;
        vecs.push_back(t);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; vld_in = 1'b0; rdy_in = 1'b0;
        pc_in = '0; alu_in = '0; rdd_in = '0; zero_in = 1'b0;
        valu_in = '0; rda_in = '0; ctrl_in = '0;
        w_rst = 1'b1; w_flush = 1'b0; w_vld_in = 1'b0; w_rdy_in = 1'b0;
        w_valu_in = '0; w_ctrl_in = '0;

        //   rst flsh vld rdy  pc          ctrl     -> v  r  occ  pc_o        ctrl_o
        add(1, 0, 0, 0, 32'h0,   4'h0,  0, 1, 0, 32'h0,   4'h0);   // reset state
        // Streaming with ready_i=1: each entry out one cycle after accept, occ<=1
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, 1, 32'h10 + i, 4'(i + 1), 1, 1, 1, 32'h10 + i, 4'(i + 1));
        add(0, 0, 0, 1, 32'h0,   4'h0,  0, 1, 0, 32'h17,  4'h0);   // drains, ctrl gated
        // Stall: A then B fills the skid; extra offer refused while full
        add(0, 0, 1, 0, 32'h100, 4'hA,  1, 1, 1, 32'h100, 4'hA);
        add(0, 0, 1, 0, 32'h104, 4'h5,  1, 0, 2, 32'h100, 4'hA);
        add(0, 0, 1, 0, 32'h108, 4'hC,  1, 0, 2, 32'h100, 4'hA);
        add(0, 0, 0, 1, 32'h0,   4'h0,  1, 1, 1, 32'h104, 4'h5);   // A released, B next
        add(0, 0, 0, 1, 32'h0,   4'h0,  0, 1, 0, 32'h104, 4'h0);
        // ctrl 1111 for one cycle then bubble; payload holds
        add(0, 0, 1, 1, 32'h200, 4'hF,  1, 1, 1, 32'h200, 4'hF);
        add(0, 0, 0, 1, 32'h0,   4'h0,  0, 1, 0, 32'h200, 4'h0);
        // Flush from FULL with a same-cycle offer
        add(0, 0, 1, 0, 32'h300, 4'h3,  1, 1, 1, 32'h300, 4'h3);
        add(0, 0, 1, 0, 32'h304, 4'h4,  1, 0, 2, 32'h300, 4'h3);
        add(0, 1, 1, 0, 32'h308, 4'h8,  0, 1, 0, 32'h300, 4'h0);
        add(0, 0, 0, 1, 32'h0,   4'h0,  0, 1, 0, 32'h300, 4'h0);   // 0x304 never appears
        add(0, 0, 1, 1, 32'h400, 4'h6,  1, 1, 1, 32'h400, 4'h6);
        add(0, 1, 1, 0, 32'h404, 4'h2,  0, 1, 0, 32'h400, 4'h0);   // flush from ONE
        // Reset while FULL with flush also high
        add(0, 0, 1, 0, 32'h500, 4'h7,  1, 1, 1, 32'h500, 4'h7);
        add(0, 0, 1, 0, 32'h504, 4'h1,  1, 0, 2, 32'h500, 4'h7);
        add(1, 1, 1, 0, 32'h508, 4'hE,  0, 1, 0, 32'h0,   4'h0);
        add(0, 0, 1, 0, 32'h600, 4'h9,  1, 1, 1, 32'h600, 4'h9);   // behaves as from EMPTY
        add(0, 0, 0, 0, 32'h0,   4'h0,  1, 1, 1, 32'h600, 4'h9);   // ONE, hold
        add(0, 0, 1, 1, 32'h604, 4'hB,  1, 1, 1, 32'h604, 4'hB);   // ONE, pass-through

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; flush = vecs[i].flush;
            vld_in = vecs[i].vld; rdy_in = vecs[i].rdy;
            pc_in = vecs[i].pc; ctrl_in = vecs[i].ctrl;
            alu_in = f_alu(vecs[i].pc); rdd_in = f_rdd(vecs[i].pc);
            rda_in = f_rda(vecs[i].pc); zero_in = f_zero(vecs[i].pc);
            valu_in = f_valu(vecs[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d valid_o", i), 256'(vld_out),  256'(vecs[i].ev));
            chk($sformatf("row%0d ready_o", i), 256'(rdy_out),  256'(vecs[i].er));
            chk($sformatf("row%0d occ_o", i),   256'(occ_out),  256'(vecs[i].eo));
            chk($sformatf("row%0d pc_o", i),    256'(pc_out),   256'(vecs[i].epc));
            chk($sformatf("row%0d ctrl_o", i),  256'(ctrl_out), 256'(vecs[i].ectrl));
            chk($sformatf("row%0d alu_o", i),   256'(alu_out),  256'(f_alu(vecs[i].epc)));
            chk($sformatf("row%0d rd_data_o", i), 256'(rdd_out), 256'(f_rdd(vecs[i].epc)));
            chk($sformatf("row%0d rd_addr_o", i), 256'(rda_out), 256'(f_rda(vecs[i].epc)));
            chk($sformatf("row%0d zero_o", i),  256'(zero_out), 256'(f_zero(vecs[i].epc)));
            chk($sformatf("row%0d valu_o", i),  256'(valu_out), 256'(f_valu(vecs[i].epc)));
        end

        // Wide vector instance: all-ones passes through unmodified, then bubble
        w_rst = 1'b1;
        @(posedge clk); #1;
        chk("wide reset valu_o", w_valu_out, 256'h0);
        chk("wide reset ready_o", 256'(w_rdy_out), 256'h1);
        w_rst = 1'b0; w_vld_in = 1'b1; w_rdy_in = 1'b1;
        w_valu_in = '1; w_ctrl_in = 4'b1001;
        @(posedge clk); #1;
        chk("wide valid_o", 256'(w_vld_out), 256'h1);
        chk("wide valu_o ones", w_valu_out, {256{1'b1}});
        chk("wide alu_o", 256'(w_alu_out), 256'hDEAD_BEEF);
        chk("wide rd_data_o", 256'(w_rdd_out), 256'h1234_5678);
        chk("wide rd_addr_o", 256'(w_rda_out), 256'd17);
        chk("wide ctrl_o", 256'(w_ctrl_out), 256'h9);
        w_vld_in = 1'b0; w_valu_in = '0;
        @(posedge clk); #1;
        chk("wide bubble valid_o", 256'(w_vld_out), 256'h0);
        chk("wide bubble ctrl_o", 256'(w_ctrl_out), 256'h0);
        chk("wide bubble valu_o held", w_valu_out, {256{1'b1}});
        chk("wide bubble occ_o", 256'(w_occ_out), 256'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
